// File: rtl/i2c_codec_responder.sv
// I2C target that decodes 3-byte codec register writes ({DEV_ADDR,W}, {reg[6:0],d[8]}, d[7:0]).
// Build option: I2C_GLITCH_FILTER_EN adds a 4-consecutive-sample filter on synchronised SCL/SDA.
module i2c_codec_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat,
    output logic       sdat_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       frame_err
);
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, IGNORE} state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_raw, sda_raw, scl_s, sda_s;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d, byte_c;
    logic [ADDR_W-1:0]   addr_nxt_q, addr_nxt_d;
    logic                data_hi_q, data_hi_d;
    logic [BYTE_W-1:0]   data_lo_q, data_lo_d;
    logic                sdat_oe_q, sdat_oe_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                frame_err_q, frame_err_d;
    logic                in_frame;

    // Input synchronisers, preset to the idle (released) bus level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_sclk};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sdat};
        end
    end

    assign scl_raw = scl_sync_q[SYNC_STAGES-1];
    assign sda_raw = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    logic       scl_filt_q, sda_filt_q;
    logic [1:0] scl_cnt_q, sda_cnt_q;

    // Output follows the input only after 4 consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            if (scl_raw == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == 2'd3) begin
                scl_filt_q <= scl_raw;
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 2'd1;
            end
            if (sda_raw == sda_filt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == 2'd3) begin
                sda_filt_q <= sda_raw;
                sda_cnt_q  <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 2'd1;
            end
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_raw;
    assign sda_s = sda_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_nxt_q  <= '0;
            data_hi_q   <= 1'b0;
            data_lo_q   <= '0;
            sdat_oe_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_nxt_q  <= addr_nxt_d;
            data_hi_q   <= data_hi_d;
            data_lo_q   <= data_lo_d;
            sdat_oe_q   <= sdat_oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Bus conditions override everything; ACK states use sdat_oe_q as their drive phase
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_nxt_d  = addr_nxt_q;
        data_hi_d   = data_hi_q;
        data_lo_d   = data_lo_q;
        sdat_oe_d   = sdat_oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        byte_c      = {shift_q[BYTE_W-2:0], sda_s};
        in_frame    = (state_q inside {ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2});

        if (start_det) begin
            frame_err_d = in_frame;
            state_d     = ADDR;
            bit_cnt_d   = '0;
            sdat_oe_d   = 1'b0;
        end else if (stop_det) begin
            frame_err_d = in_frame;
            state_d     = IDLE;
            sdat_oe_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise) begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            if (state_q == ADDR) begin
                                state_d = (byte_c == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                            end else if (state_q == BYTE1) begin
                                addr_nxt_d = byte_c[BYTE_W-1:1];
                                data_hi_d  = byte_c[0];
                                state_d    = ACK1;
                            end else begin
                                data_lo_d = byte_c;
                                state_d   = ACK2;
                            end
                        end
                    end
                end
                ACK_A, ACK1, ACK2: begin
                    if (scl_fall) begin
                        if (!sdat_oe_q) begin
                            sdat_oe_d = 1'b1;
                        end else begin
                            sdat_oe_d = 1'b0;
                            if (state_q == ACK_A) begin
                                state_d = BYTE1;
                            end else if (state_q == ACK1) begin
                                state_d = BYTE2;
                            end else begin
                                wr_addr_d  = addr_nxt_q;
                                wr_data_d  = {data_hi_q, data_lo_q};
                                wr_valid_d = 1'b1;
                                state_d    = IGNORE;
                            end
                        end
                    end
                end
                default: sdat_oe_d = 1'b0;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    assign sdat_oe   = sdat_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: models the write initiator and the SDA pull-up.
module tb_i2c_codec_responder;
    localparam int unsigned Q = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_drv;
    logic       sda_drv;
    logic       i2c_sdat;
    logic       sdat_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt = 0, ecnt = 0, oecnt = 0, bothcnt = 0;
    int v0, e0, o0;
    logic glitch_en = 1'b0;
    logic a0, a1, a2, a3;

    assign i2c_sdat = sda_drv & ~sdat_oe;

    i2c_codec_responder dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_sclk  (scl_drv),
        .i2c_sdat  (i2c_sdat),
        .sdat_oe   (sdat_oe),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_valid) vcnt++;
        if (frame_err) ecnt++;
        if (sdat_oe) oecnt++;
        if (wr_valid && frame_err) bothcnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        #Q scl_drv = 1'b1;
        #Q sda_drv = 1'b0;
        #Q scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_drv = 1'b0;
        #Q scl_drv = 1'b1;
        #Q sda_drv = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q sda_drv = b;
`ifdef I2C_GLITCH_FILTER_EN
        if (glitch_en) begin
            #200 scl_drv = 1'b1;
            #40 scl_drv = 1'b0;
            #(Q - 240);
        end else begin
            #Q;
        end
`else
        #Q;
`endif
        scl_drv = 1'b1;
        #Q;
        #Q scl_drv = 1'b0;
    endtask

    // Eight data bits then a released 9th bit; ack=1 when the target pulled SDA low
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #Q sda_drv = 1'b1;
        #Q scl_drv = 1'b1;
        #Q ack = ~i2c_sdat;
        #Q scl_drv = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        #95;
        check("rst_oe", 32'(sdat_oe), 32'h0);
        check("rst_valid", 32'(wr_valid), 32'h0);
        check("rst_addr", 32'(wr_addr), 32'h0);
        check("rst_data", 32'(wr_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        reset = 1'b1;
        #1000;

        // 1: full write frame 0x34,0x1E,0x00
        v0 = vcnt; e0 = ecnt;
        i2c_start();
        #200 check("t1_busy", 32'(busy), 32'h1);
        send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
        i2c_stop();
        check("t1_acks", 32'({a0, a1, a2}), 32'h7);
        check("t1_nvalid", 32'(vcnt - v0), 32'h1);
        check("t1_addr", 32'(wr_addr), 32'h0F);
        check("t1_data", 32'(wr_data), 32'h000);
        check("t1_nferr", 32'(ecnt - e0), 32'h0);

        // 2: 0x34,0x08,0x15; busy drops at STOP
        v0 = vcnt;
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h15, a2);
        check("t2_busy_pre", 32'(busy), 32'h1);
        i2c_stop();
        check("t2_acks", 32'({a0, a1, a2}), 32'h7);
        check("t2_nvalid", 32'(vcnt - v0), 32'h1);
        check("t2_addr", 32'(wr_addr), 32'h04);
        check("t2_data", 32'(wr_data), 32'h015);
        check("t2_busy_post", 32'(busy), 32'h0);

        // 3: wrong device address is never acknowledged
        v0 = vcnt; e0 = ecnt; o0 = oecnt;
        i2c_start();
        send_byte(8'h36, a0); send_byte(8'h08, a1); send_byte(8'h15, a2);
        i2c_stop();
        check("t3_acks", 32'({a0, a1, a2}), 32'h0);
        check("t3_oe", 32'(oecnt - o0), 32'h0);
        check("t3_nvalid", 32'(vcnt - v0), 32'h0);
        check("t3_nferr", 32'(ecnt - e0), 32'h0);

        // 4: STOP after two bytes is a frame error, outputs hold
        v0 = vcnt; e0 = ecnt;
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h1E, a1);
        i2c_stop();
        check("t4_acks", 32'({a0, a1}), 32'h3);
        check("t4_ferr_width", 32'(ecnt - e0), 32'h1);
        check("t4_nvalid", 32'(vcnt - v0), 32'h0);
        check("t4_addr", 32'(wr_addr), 32'h04);
        check("t4_data", 32'(wr_data), 32'h015);

        // 5: reset during bit 4 of byte 2, then a clean frame
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h1E, a1);
        for (int i = 7; i >= 5; i--) send_bit(1'b0);
        #Q sda_drv = 1'b1;
        #Q scl_drv = 1'b1;
        #200 reset = 1'b0;
        #1;
        check("t5_oe", 32'(sdat_oe), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_addr", 32'(wr_addr), 32'h0);
        scl_drv = 1'b1; sda_drv = 1'b1;
        #200 reset = 1'b1;
        #1000;
        v0 = vcnt;
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h15, a2);
        i2c_stop();
        check("t5_acks", 32'({a0, a1, a2}), 32'h7);
        check("t5_nvalid", 32'(vcnt - v0), 32'h1);
        check("t5_addr2", 32'(wr_addr), 32'h04);
        check("t5_data2", 32'(wr_data), 32'h015);

        // 6: read NACKed, then repeated START with a 4-byte write
        v0 = vcnt; e0 = ecnt;
        i2c_start();
        send_byte(8'h35, a0);
        check("t6_read_nack", 32'(a0), 32'h0);
        i2c_start();
        send_byte(8'h34, a0);
        glitch_en = 1'b1;
        send_byte(8'h12, a1);
        glitch_en = 1'b0;
        send_byte(8'h34, a2); send_byte(8'hAA, a3);
        i2c_stop();
        check("t6_acks", 32'({a0, a1, a2, a3}), 32'hE);
        check("t6_nvalid", 32'(vcnt - v0), 32'h1);
        check("t6_addr", 32'(wr_addr), 32'h09);
        check("t6_data", 32'(wr_data), 32'h034);
        check("t6_nferr", 32'(ecnt - e0), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("no_overlap", 32'(bothcnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
